int_gen: RTL and testbench

Programmable external interrupt source that sits on the far side of the CPU's interrupt-acknowledge port. It raises `interrupt`, which feeds HWInt bit 2 of the CPU, on a configurable schedule. It holds the request until the interrupt handler acknowledges it by storing to the acknowledge address through `m_int_addr`/`m_int_byteen`. The block is the system-level stimulus for exception and interrupt verification of the pipelined CPU.

---
 rtl/int_gen.sv | 195 +++++++++++++++++++
 tb/tb_int_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/int_gen.sv
// rtl/int_gen.sv - programmable interrupt source with store-based acknowledge
// Optional watchdog: define INT_GEN_TIMEOUT_EN to force-drop unacknowledged requests after TIMEOUT cycles.
module int_gen #(
  parameter logic [31:0] INT_ADDR = 32'h0000_7F20,
  parameter logic [3:0]  HOLDOFF  = 4'd2,
  parameter logic [31:0] TIMEOUT  = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_int_addr,
  input  logic [3:0]  m_int_byteen,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        interrupt,
  output logic        busy,
  output logic [15:0] fired_cnt,
  output logic [7:0]  spurious_cnt,
  output logic        timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_ASSERT,
    S_HOLDOFF,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic [15:0] limit_q, limit_d;
  logic        en_q, en_d;
  logic        rpt_q, rpt_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [15:0] fired_q, fired_d;
  logic [7:0]  spur_q, spur_d;
  logic        irq_q, irq_d;
`ifdef INT_GEN_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic        tflag_q, tflag_d;
`endif

  logic        ack;
  logic        ctrl_wr;
  logic [31:0] period_eff;
  logic        unused_bits;

  // Word-address match; byte offset within the word does not matter.
  assign ack        = (m_int_addr[31:2] == INT_ADDR[31:2]) && (m_int_byteen != 4'd0);
  assign ctrl_wr    = cfg_we && (cfg_addr == 2'd2);
  // A zero period would never hit the cnt==1 compare, so it behaves as 1.
  assign period_eff = (period_q == 32'd0) ? 32'd1 : period_q;

  // Configuration register writes; the countdown only picks these up on reload.
  always_comb begin
    period_d = period_q;
    limit_d  = limit_q;
    en_d     = en_q;
    rpt_d    = rpt_q;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0: period_d = cfg_wdata;
        2'd1: limit_d  = cfg_wdata[15:0];
        2'd2: begin
          en_d  = cfg_wdata[0];
          rpt_d = cfg_wdata[1];
        end
        default: ;
      endcase
    end
  end

  // Schedule FSM; a CTRL write overrides everything, including a same-cycle ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    fired_d = fired_q;
    spur_d  = spur_q;
`ifdef INT_GEN_TIMEOUT_EN
    wdog_d  = 32'd0;
    tflag_d = tflag_q;
`endif
    if (ctrl_wr) begin
      state_d = S_IDLE;
      fired_d = 16'd0;
      spur_d  = 8'd0;
`ifdef INT_GEN_TIMEOUT_EN
      tflag_d = 1'b0;
`endif
    end else begin
      if (ack && (state_q != S_ASSERT) && (spur_q != 8'hFF)) begin
        spur_d = spur_q + 8'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (en_q) begin
            cnt_d   = period_eff;
            state_d = S_COUNT;
          end
        end
        S_COUNT: begin
          if (cnt_q == 32'd1) begin
            state_d = S_ASSERT;
            if (fired_q != 16'hFFFF) begin
              fired_d = fired_q + 16'd1;
            end
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_ASSERT: begin
          if (ack) begin
            state_d = S_HOLDOFF;
            hcnt_d  = HOLDOFF;
          end
`ifdef INT_GEN_TIMEOUT_EN
          else if (wdog_q == TIMEOUT - 32'd1) begin
            state_d = S_HOLDOFF;
            hcnt_d  = HOLDOFF;
            tflag_d = 1'b1;
          end else begin
            wdog_d = wdog_q + 32'd1;
          end
`endif
        end
        S_HOLDOFF: begin
          if (hcnt_q == 4'd0) begin
            if (rpt_q && ((limit_q == 16'd0) || (fired_q < limit_q))) begin
              cnt_d   = period_eff;
              state_d = S_COUNT;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            hcnt_d = hcnt_q - 4'd1;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
    irq_d = (state_d == S_ASSERT);
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      period_q <= 32'd1;
      limit_q  <= 16'd0;
      en_q     <= 1'b0;
      rpt_q    <= 1'b0;
      cnt_q    <= 32'd0;
      hcnt_q   <= 4'd0;
      fired_q  <= 16'd0;
      spur_q   <= 8'd0;
      irq_q    <= 1'b0;
`ifdef INT_GEN_TIMEOUT_EN
      wdog_q   <= 32'd0;
      tflag_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      limit_q  <= limit_d;
      en_q     <= en_d;
      rpt_q    <= rpt_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      fired_q  <= fired_d;
      spur_q   <= spur_d;
      irq_q    <= irq_d;
`ifdef INT_GEN_TIMEOUT_EN
      wdog_q   <= wdog_d;
      tflag_q  <= tflag_d;
`endif
    end
  end

  assign interrupt    = irq_q;
  assign busy         = (state_q == S_COUNT) || (state_q == S_ASSERT) || (state_q == S_HOLDOFF);
  assign fired_cnt    = fired_q;
  assign spurious_cnt = spur_q;
`ifdef INT_GEN_TIMEOUT_EN
  assign timeout_flag = tflag_q;
  assign unused_bits  = ^m_int_addr[1:0];
`else
  assign timeout_flag = 1'b0;
  assign unused_bits  = ^{m_int_addr[1:0], TIMEOUT};
`endif

endmodule

// File: tb/tb_int_gen.sv
// tb/tb_int_gen.sv - directed self-checking bench for int_gen
module tb_int_gen;

  logic        clk;
  logic        reset;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        interrupt;
  logic        busy;
  logic [15:0] fired_cnt;
  logic [7:0]  spurious_cnt;
  logic        timeout_flag;

  int n_cmp = 0;
  int n_err = 0;

  int_gen #(
    .INT_ADDR(32'h0000_7F20),
    .HOLDOFF (4'd2),
    .TIMEOUT (32'd8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_int_addr  (m_int_addr),
    .m_int_byteen(m_int_byteen),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .interrupt   (interrupt),
    .busy        (busy),
    .fired_cnt   (fired_cnt),
    .spurious_cnt(spurious_cnt),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    cyc();
    cfg_we    = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] be);
    m_int_addr   = a;
    m_int_byteen = be;
    cyc();
    m_int_addr   = 32'd0;
    m_int_byteen = 4'd0;
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    while (!interrupt && n < max) begin
      cyc();
      n++;
    end
  endtask

  int n;
  int k;

  initial begin
    reset        = 1'b0;
    m_int_addr   = 32'd0;
    m_int_byteen = 4'd0;
    cfg_we       = 1'b0;
    cfg_addr     = 2'd0;
    cfg_wdata    = 32'd0;
    cyc();
    cyc();
    reset = 1'b1;
    check("rst_irq", 32'(interrupt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fired", 32'(fired_cnt), 32'd0);
    check("rst_spur", 32'(spurious_cnt), 32'd0);
    check("rst_tflag", 32'(timeout_flag), 32'd0);

    // single shot, PERIOD=5
    cfg_wr(2'd0, 32'd5);
    cfg_wr(2'd2, 32'd1);
    cyc();
    check("t1_busy_count", 32'(busy), 32'd1);
    wait_irq(50, n);
    check("t1_latency", 32'(n), 32'd5);
    check("t1_fired", 32'(fired_cnt), 32'd1);
    store(32'h0000_7F20, 4'hF);
    check("t1_irq_drop", 32'(interrupt), 32'd0);
    for (int i = 0; i < 6; i++) cyc();
    check("t1_done_busy", 32'(busy), 32'd0);
    check("t1_done_irq", 32'(interrupt), 32'd0);
    check("t1_done_fired", 32'(fired_cnt), 32'd1);

    // repeat mode, PERIOD=3 LIMIT=4
    cfg_wr(2'd0, 32'd3);
    cfg_wr(2'd1, 32'd4);
    cfg_wr(2'd2, 32'd3);
    for (int i = 0; i < 4; i++) begin
      wait_irq(50, n);
      check($sformatf("t2_gap%0d", i), 32'(n), (i == 0) ? 32'd4 : 32'd6);
      check($sformatf("t2_fired%0d", i), 32'(fired_cnt), 32'(i + 1));
      cyc();
      store(32'h0000_7F20, 4'hF);
    end
    for (int i = 0; i < 12; i++) cyc();
    check("t2_fired_end", 32'(fired_cnt), 32'd4);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_irq_end", 32'(interrupt), 32'd0);
    check("t2_spur", 32'(spurious_cnt), 32'd0);

    // spurious acknowledges and address/byteen decode
    cfg_wr(2'd1, 32'd0);
    cfg_wr(2'd0, 32'd2);
    cfg_wr(2'd2, 32'd1);
    store(32'h0000_7F20, 4'hF);
    check("t3_spur_idle", 32'(spurious_cnt), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    wait_irq(50, n);
    check("t3_latency", 32'(n), 32'd2);
    store(32'h0000_7F24, 4'b0001);
    check("t3_other_addr_irq", 32'(interrupt), 32'd1);
    check("t3_other_addr_spur", 32'(spurious_cnt), 32'd1);
    store(32'h0000_7F20, 4'b0000);
    check("t3_no_be_irq", 32'(interrupt), 32'd1);
    store(32'h0000_7F23, 4'b0100);
    check("t3_low_bits_ack", 32'(interrupt), 32'd0);
    check("t3_spur_after_ack", 32'(spurious_cnt), 32'd1);
    store(32'h0000_7F20, 4'hF);
    check("t3_stall_spur", 32'(spurious_cnt), 32'd2);

    // CTRL write colliding with ACK in ASSERT
    cfg_wr(2'd0, 32'd3);
    cfg_wr(2'd2, 32'd1);
    wait_irq(50, n);
    check("t4_latency", 32'(n), 32'd4);
    check("t4_fired", 32'(fired_cnt), 32'd1);
    cfg_we       = 1'b1;
    cfg_addr     = 2'd2;
    cfg_wdata    = 32'd1;
    m_int_addr   = 32'h0000_7F20;
    m_int_byteen = 4'hF;
    cyc();
    cfg_we       = 1'b0;
    m_int_addr   = 32'd0;
    m_int_byteen = 4'd0;
    check("t4_irq_low", 32'(interrupt), 32'd0);
    check("t4_spur", 32'(spurious_cnt), 32'd0);
    check("t4_fired_clr", 32'(fired_cnt), 32'd0);
    wait_irq(50, n);
    check("t4_rearm", 32'(n), 32'd4);

    // reset while asserted
    cfg_wr(2'd0, 32'd7);
    cfg_wr(2'd1, 32'd9);
    store(32'h0000_7F24, 4'hF);
    check("t5_irq_before", 32'(interrupt), 32'd1);
    reset = 1'b0;
    cyc();
    check("t5_irq_on_reset", 32'(interrupt), 32'd0);
    reset = 1'b1;
    check("t5_fired", 32'(fired_cnt), 32'd0);
    check("t5_spur", 32'(spurious_cnt), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    cyc();
    cyc();
    check("t5_ctrl_cleared", 32'(busy), 32'd0);
    cfg_wr(2'd2, 32'd1);
    wait_irq(50, n);
    check("t5_period_one", 32'(n), 32'd2);

    // watchdog: no acknowledge ever arrives
    k = 0;
    while (interrupt && k < 20) begin
      cyc();
      k++;
    end
`ifdef INT_GEN_TIMEOUT_EN
    check("t6_hold_cycles", 32'(k), 32'd8);
    check("t6_tflag", 32'(timeout_flag), 32'd1);
`else
    check("t6_hold_cycles", 32'(k), 32'd20);
    check("t6_tflag", 32'(timeout_flag), 32'd0);
`endif
    cfg_wr(2'd2, 32'd0);
    check("t6_tflag_clr", 32'(timeout_flag), 32'd0);
    check("t6_irq_off", 32'(interrupt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
